fifo_pack_writer: RTL

Write-side front end for `async_fifo` when `INPUT_WIDTH < OUTPUT_WIDTH`. It accepts a valid/ready packet stream in the `wr_clk` domain and drives `wr_en`/`din` of the FIFO, throttling on FIFO space. It pads every packet with filler beats so that each packet ends exactly on an `OUTPUT_WIDTH` word boundary. As a result, the read side never sees a wide word mixing two packets, and no partial word stays stuck in the FIFO.

---
 rtl/fifo_pack_writer_if.sv | 26 ++
 rtl/fifo_pack_writer.sv | 72 +++++++
 2 files changed

// File: rtl/fifo_pack_writer_if.sv
// Narrow packet stream in plus the write port of the wide-output async FIFO.
interface fifo_pack_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int WR_DEPTH   = 128
);
    logic                        s_valid;
    logic                        s_ready;
    logic [DATA_WIDTH-1:0]       s_data;
    logic                        s_last;
    logic                        fifo_wr_en;
    logic [DATA_WIDTH-1:0]       fifo_din;
    logic                        fifo_full;
    logic [$clog2(WR_DEPTH):0]   fifo_wr_data_space;

    // Environment side: sources the stream and models the FIFO.
    modport master (
        output s_valid, s_data, s_last, fifo_full, fifo_wr_data_space,
        input  s_ready, fifo_wr_en, fifo_din
    );

    // Packer side: sinks the stream and drives the FIFO write port.
    modport slave (
        input  s_valid, s_data, s_last, fifo_full, fifo_wr_data_space,
        output s_ready, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_pack_writer.sv
// Packs narrow packets into the FIFO, padding each to a RATIO-beat wide-word boundary.
// Latency: handshake at edge N -> fifo_wr_en/fifo_din valid during cycle N+1.
// Backpressure: s_ready follows FIFO space (margin of 2) and is held low while padding.
module fifo_pack_writer #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    RATIO      = 8,
    parameter int                    WR_DEPTH   = 128,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                 wr_clk,
    input  logic                 sys_rst,
    fifo_pack_writer_if.slave    bus,
    output logic [15:0]          pkt_count,
    output logic [15:0]          pad_count,
    output logic                 busy
);
    localparam int            CW       = $clog2(RATIO);
    localparam int            SW       = $clog2(WR_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_POS = CW'(RATIO - 1);

    typedef enum logic {ACCEPT, PAD} state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic          space_ok;
    logic          hs;

    // Margin of 2 covers the registered write plus the FIFO's count-update delay.
    assign space_ok    = !bus.fifo_full && (bus.fifo_wr_data_space > SW'(2));
    assign bus.s_ready = (state == ACCEPT) && space_ok;
    assign hs          = bus.s_valid && bus.s_ready;
    assign busy        = (state == PAD) || (beat_cnt != '0);

    always_ff @(posedge wr_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state          <= ACCEPT;
            beat_cnt       <= '0;
            bus.fifo_wr_en <= 1'b0;
            bus.fifo_din   <= '0;
            pkt_count      <= '0;
            pad_count      <= '0;
        end else begin
            bus.fifo_wr_en <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (hs) begin
                        bus.fifo_wr_en <= 1'b1;
                        bus.fifo_din   <= bus.s_data;
                        beat_cnt       <= beat_cnt + CW'(1);
                        if (bus.s_last) begin
                            pkt_count <= pkt_count + 16'd1;
                            // A packet ending on the last word slot is already aligned.
                            if (beat_cnt != LAST_POS)
                                state <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (space_ok) begin
                        bus.fifo_wr_en <= 1'b1;
                        bus.fifo_din   <= PAD_VALUE;
                        beat_cnt       <= beat_cnt + CW'(1);
                        pad_count      <= pad_count + 16'd1;
                        if (beat_cnt == LAST_POS)
                            state <= ACCEPT;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end
endmodule
